cpsr_issue_ctrl: RTL and testbench

Issue-stage controller for conditional execution. It owns the architectural CPSR flags (Z, C, N, V), counts in-flight flag-setting instructions, and stalls conditional instructions until their flags are final. For each accepted instruction it emits a registered execute/squash decision. It sits between decode and the execute stage; writeback returns new flags to it.

---
 rtl/cpsr_issue_ctrl_pkg.sv | 43 ++++
 rtl/cpsr_issue_ctrl_if.sv | 48 ++++
 rtl/cpsr_issue_ctrl_cond_eval.sv | 44 ++++
 rtl/cpsr_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_cpsr_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpsr_issue_ctrl_pkg.sv
// Shared definitions for the CPSR issue controller: condition codes, flag
// bit positions, pending-state encoding and the state classification helper.
package cpsr_issue_ctrl_pkg;

    localparam logic [3:0] EQ = 4'b0000;
    localparam logic [3:0] NE = 4'b0001;
    localparam logic [3:0] CS = 4'b0010;
    localparam logic [3:0] CC = 4'b0011;
    localparam logic [3:0] MI = 4'b0100;
    localparam logic [3:0] PL = 4'b0101;
    localparam logic [3:0] VS = 4'b0110;
    localparam logic [3:0] VC = 4'b0111;
    localparam logic [3:0] HI = 4'b1000;
    localparam logic [3:0] LS = 4'b1001;
    localparam logic [3:0] GE = 4'b1010;
    localparam logic [3:0] LT = 4'b1011;
    localparam logic [3:0] GT = 4'b1100;
    localparam logic [3:0] LE = 4'b1101;
    localparam logic [3:0] AL = 4'b1110;
    localparam logic [3:0] NV = 4'b1111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } state_e;

    // Classifies a pending count against the configured in-flight limit.
    function automatic state_e state_of(input int pend, input int maxPend);
        if (pend == 0) begin
            return IDLE;
        end else if (pend >= maxPend) begin
            return FULL;
        end
        return BUSY;
    endfunction

endpackage

// File: rtl/cpsr_issue_ctrl_if.sv
// Decode/execute/writeback bundle between the pipeline and the CPSR issue
// controller; master is the pipeline side, slave is the controller.
interface cpsr_issue_ctrl_if;

    logic       flush;
    logic       issue_valid;
    logic [3:0] issue_cond;
    logic       issue_setflags;
    logic       issue_ready;
    logic       exec_valid;
    logic       exec_take;
    logic       exec_setflags;
    logic       wb_flag_valid;
    logic [3:0] wb_flags;
    logic [3:0] cpsr;
    logic       err_underflow;

    modport master (
        output flush,
        output issue_valid,
        output issue_cond,
        output issue_setflags,
        output wb_flag_valid,
        output wb_flags,
        input  issue_ready,
        input  exec_valid,
        input  exec_take,
        input  exec_setflags,
        input  cpsr,
        input  err_underflow
    );

    modport slave (
        input  flush,
        input  issue_valid,
        input  issue_cond,
        input  issue_setflags,
        input  wb_flag_valid,
        input  wb_flags,
        output issue_ready,
        output exec_valid,
        output exec_take,
        output exec_setflags,
        output cpsr,
        output err_underflow
    );

endinterface

// File: rtl/cpsr_issue_ctrl_cond_eval.sv
// Purely combinational condition-code evaluator: (cond, flags) -> take.
// Shared by the architectural path and the writeback forwarding path.
module cpsr_issue_ctrl_cond_eval
    import cpsr_issue_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       take_o
);

    logic flagZ;
    logic flagC;
    logic flagN;
    logic flagV;
    logic base;

    assign flagZ = flags_i[FLAG_Z];
    assign flagC = flags_i[FLAG_C];
    assign flagN = flags_i[FLAG_N];
    assign flagV = flags_i[FLAG_V];

    // AL/NV share the 3'b111 code slot, so they override the inverted base.
    always_comb begin
        base = 1'b0;
        case (cond_i[3:1])
            3'b000:  base = flagZ;
            3'b001:  base = flagC;
            3'b010:  base = flagN;
            3'b011:  base = flagV;
            3'b100:  base = flagC & ~flagZ;
            3'b101:  base = (flagN == flagV);
            3'b110:  base = ~flagZ & (flagN == flagV);
            default: base = 1'b0;
        endcase

        take_o = base ^ cond_i[0];
        if (cond_i == AL) begin
            take_o = 1'b1;
        end else if (cond_i == NV) begin
            take_o = 1'b0;
        end
    end

endmodule

// File: rtl/cpsr_issue_ctrl.sv
// Issue-stage controller owning the CPSR flags and the in-flight flag-setter count.
// Optional feature: define CPSR_BYPASS_EN to forward writeback flags to a stalled conditional.
module cpsr_issue_ctrl
    import cpsr_issue_ctrl_pkg::*;
#(
    parameter int MAX_PENDING = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    cpsr_issue_ctrl_if.slave   bus
);

    localparam int PW = $clog2(MAX_PENDING + 1);

    logic [PW-1:0] pend_q;
    logic [PW-1:0] pend_d;
    state_e        state_q;
    state_e        state_d;
    logic [3:0]    cpsr_q;
    logic [3:0]    cpsr_d;
    logic          err_q;
    logic          err_d;
    logic          execValid_q;
    logic          execValid_d;
    logic          execTake_q;
    logic          execTake_d;
    logic          execSet_q;
    logic          execSet_d;

    logic takeArch;
    logic takeFwd;
    logic takeEval;
    logic bypassHit;
    logic stallFull;
    logic stallHazard;
    logic ready;
    logic accept;
    logic incPend;
    logic decPend;

    cpsr_issue_ctrl_cond_eval u_condArch (
        .cond_i  (bus.issue_cond),
        .flags_i (cpsr_q),
        .take_o  (takeArch)
    );

`ifdef CPSR_BYPASS_EN
    cpsr_issue_ctrl_cond_eval u_condFwd (
        .cond_i  (bus.issue_cond),
        .flags_i (bus.wb_flags),
        .take_o  (takeFwd)
    );

    // Forwarding only when the last pending writeback lands now and the
    // waiting instruction would not itself add a new pending flag write.
    assign bypassHit = bus.wb_flag_valid
                     & (pend_q == PW'(1))
                     & (bus.issue_cond != AL)
                     & ~(bus.issue_setflags & takeFwd);
`else
    assign takeFwd   = 1'b0;
    assign bypassHit = 1'b0;
`endif

    assign stallFull   = bus.issue_setflags & (state_q == FULL);
    assign stallHazard = (bus.issue_cond != AL) & (state_q != IDLE) & ~bypassHit;
    assign ready       = ~bus.flush & ~(bus.issue_valid & (stallFull | stallHazard));
    assign accept      = bus.issue_valid & ready;

    assign takeEval = bypassHit ? takeFwd : takeArch;
    assign incPend  = accept & bus.issue_setflags & takeEval;
    assign decPend  = bus.wb_flag_valid & (pend_q != '0);

    // Next-state: pending count, flags, sticky underflow and the one-cycle execute decision.
    always_comb begin
        pend_d = pend_q;
        if (bus.flush) begin
            pend_d = '0;
        end else if (incPend & ~decPend) begin
            pend_d = pend_q + PW'(1);
        end else if (decPend & ~incPend) begin
            pend_d = pend_q - PW'(1);
        end

        cpsr_d      = bus.wb_flag_valid ? bus.wb_flags : cpsr_q;
        err_d       = err_q | (bus.wb_flag_valid & (pend_q == '0));
        execValid_d = accept;
        execTake_d  = accept & takeEval;
        execSet_d   = accept & takeEval & bus.issue_setflags;
        state_d     = state_of(int'(pend_d), MAX_PENDING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            state_q     <= IDLE;
            cpsr_q      <= '0;
            err_q       <= 1'b0;
            execValid_q <= 1'b0;
            execTake_q  <= 1'b0;
            execSet_q   <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            state_q     <= state_d;
            cpsr_q      <= cpsr_d;
            err_q       <= err_d;
            execValid_q <= execValid_d;
            execTake_q  <= execTake_d;
            execSet_q   <= execSet_d;
        end
    end

    assign bus.issue_ready   = ready;
    assign bus.exec_valid    = execValid_q;
    assign bus.exec_take     = execTake_q;
    assign bus.exec_setflags = execSet_q;
    assign bus.cpsr          = cpsr_q;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_cpsr_issue_ctrl.sv
// Bench for cpsr_issue_ctrl: directed scenarios plus randomized traffic against
// a pending-count/flags reference model. Honors CPSR_BYPASS_EN like the design.
module tb_cpsr_issue_ctrl;

    localparam int MAX_PENDING = 3;
`ifdef CPSR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cpsr_issue_ctrl_if bus();

    cpsr_issue_ctrl #(.MAX_PENDING(MAX_PENDING)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         mPend;
    logic [3:0] mCpsr;
    logic       mErr;
    logic       mExecValid;
    logic       mExecTake;
    logic       mExecSet;
    logic       obsReady;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Condition rules written straight from the flag semantics.
    function automatic logic refTake(input logic [3:0] cnd, input logic [3:0] f);
        logic z, c, n, v, b;
        z = f[0]; c = f[1]; n = f[2]; v = f[3];
        if (cnd == 4'b1110) return 1'b1;
        if (cnd == 4'b1111) return 1'b0;
        case (cnd[3:1])
            3'd0: b = z;
            3'd1: b = c;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = c && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b0;
        endcase
        return b ^ cnd[0];
    endfunction

    function automatic logic refReady(input logic valid, input logic [3:0] cnd, input logic setf,
                                      input logic wbv, input logic [3:0] wbf, input logic fl);
        if (fl) return 1'b0;
        if (!valid) return 1'b1;
        if (setf && mPend == MAX_PENDING) return 1'b0;
        if (cnd != 4'b1110 && mPend != 0) begin
            if (BYPASS && mPend == 1 && wbv && !(setf && refTake(cnd, wbf))) return 1'b1;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void modelReset();
        mPend = 0; mCpsr = 4'h0; mErr = 1'b0;
        mExecValid = 1'b0; mExecTake = 1'b0; mExecSet = 1'b0;
    endfunction

    task automatic applyStimulus(input logic valid, input logic [3:0] cnd, input logic setf,
                                 input logic wbv, input logic [3:0] wbf, input logic fl);
        logic expReady, accept, tk, inc, dec;
        logic [3:0] evalFlags;
        @(negedge clk);
        bus.issue_valid    = valid;
        bus.issue_cond     = cnd;
        bus.issue_setflags = setf;
        bus.wb_flag_valid  = wbv;
        bus.wb_flags       = wbf;
        bus.flush          = fl;
        #1;
        expReady = refReady(valid, cnd, setf, wbv, wbf, fl);
        obsReady = bus.issue_ready;
        checkOutput("issue_ready", bus.issue_ready, {3'b0, expReady});

        accept    = valid && expReady;
        evalFlags = (accept && mPend != 0) ? wbf : mCpsr;
        tk        = refTake(cnd, evalFlags);
        inc       = accept && setf && tk;
        dec       = 1'b0;
        mExecValid = accept;
        mExecTake  = accept && tk;
        mExecSet   = accept && tk && setf;
        if (wbv) begin
            mCpsr = wbf;
            if (mPend == 0) mErr = 1'b1;
            else dec = 1'b1;
        end
        mPend = fl ? 0 : mPend + int'(inc) - int'(dec);

        @(posedge clk);
        #1;
        checkOutput("exec_valid", bus.exec_valid, {3'b0, mExecValid});
        checkOutput("exec_take", bus.exec_take, {3'b0, mExecTake});
        checkOutput("exec_setflags", bus.exec_setflags, {3'b0, mExecSet});
        checkOutput("cpsr", bus.cpsr, mCpsr);
        checkOutput("err_underflow", bus.err_underflow, {3'b0, mErr});
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic issueAlSetter();
        applyStimulus(1'b1, 4'b1110, 1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic writeback(input logic [3:0] f);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, f, 1'b0);
    endtask

    initial begin
        logic       rv, rs, rw, rf;
        logic [3:0] rc, rwf;

        bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_cond = 4'h0;
        bus.issue_setflags = 1'b0; bus.wb_flag_valid = 1'b0; bus.wb_flags = 4'h0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_exec_valid", bus.exec_valid, 4'h0);
        checkOutput("rst_exec_take", bus.exec_take, 4'h0);
        checkOutput("rst_exec_setflags", bus.exec_setflags, 4'h0);
        checkOutput("rst_cpsr", bus.cpsr, 4'h0);
        checkOutput("rst_err", bus.err_underflow, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", bus.issue_ready, 4'h1);

        // EQ / NE against cleared flags
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("eq_take", bus.exec_take, 4'h0);
        checkOutput("eq_valid", bus.exec_valid, 4'h1);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("ne_take", bus.exec_take, 4'h1);

        // Fill to MAX_PENDING, then the fourth setter waits for a writeback
        repeat (3) issueAlSetter();
        applyStimulus(1'b1, 4'b1110, 1'b1, 1'b0, 4'h0, 1'b0);
        checkOutput("full_stall", {3'b0, obsReady}, 4'h0);
        applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1, 4'h0, 1'b0);
        checkOutput("full_stall_wb", {3'b0, obsReady}, 4'h0);
        issueAlSetter();
        checkOutput("full_accept", {3'b0, obsReady}, 4'h1);
        repeat (3) writeback(4'h0);

        // Conditional stalled behind the last writeback
        issueAlSetter();
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("hazard_stall", {3'b0, obsReady}, 4'h0);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0);
`ifdef CPSR_BYPASS_EN
        checkOutput("bypass_accept", {3'b0, obsReady}, 4'h1);
        checkOutput("bypass_take", bus.exec_take, 4'h1);
`else
        checkOutput("wb_cycle_stall", {3'b0, obsReady}, 4'h0);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("post_wb_accept", {3'b0, obsReady}, 4'h1);
        checkOutput("post_wb_take", bus.exec_take, 4'h1);
`endif

        // Squashed flag-setter does not count as pending
        issueAlSetter();
        writeback(4'b0010);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 4'h0, 1'b0);
        checkOutput("squash_take", bus.exec_take, 4'h0);
        checkOutput("squash_setflags", bus.exec_setflags, 4'h0);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("squash_no_pend", {3'b0, obsReady}, 4'h1);

        // Simultaneous increment and decrement at P=2
        repeat (2) issueAlSetter();
        applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1, 4'b0101, 1'b0);
        checkOutput("incdec_cpsr", bus.cpsr, 4'b0101);
        issueAlSetter();
        applyStimulus(1'b1, 4'b1110, 1'b1, 1'b0, 4'h0, 1'b0);
        checkOutput("incdec_full", {3'b0, obsReady}, 4'h0);
        repeat (3) writeback(4'h0);

        // Flush drops pending count; later writeback underflows
        repeat (2) issueAlSetter();
        applyStimulus(1'b1, 4'b1110, 1'b1, 1'b0, 4'h0, 1'b1);
        checkOutput("flush_ready", {3'b0, obsReady}, 4'h0);
        writeback(4'b1000);
        checkOutput("underflow_cpsr", bus.cpsr, 4'b1000);
        checkOutput("underflow_err", bus.err_underflow, 4'h1);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("flush_idle", {3'b0, obsReady}, 4'h1);

        // Asynchronous reset mid-operation
        issueAlSetter();
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_cpsr", bus.cpsr, 4'h0);
        checkOutput("async_rst_err", bus.err_underflow, 4'h0);
        checkOutput("async_rst_valid", bus.exec_valid, 4'h0);
        modelReset();
        bus.issue_valid = 1'b0; bus.wb_flag_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rv  = ($urandom_range(0, 9) < 7);
            rc  = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
            rs  = $urandom_range(0, 1) == 1;
            rw  = (mPend > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            rwf = 4'($urandom_range(0, 15));
            rf  = ($urandom_range(0, 31) == 0);
            applyStimulus(rv, rc, rs, rw, rwf, rf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
